// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared encodings for the multi-cycle MIPS main control
package multicycle_control_pkg;

  // Supported opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B         = 2'b00;
  localparam logic [1:0] SRCB_FOUR      = 2'b01;
  localparam logic [1:0] SRCB_IMM       = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - combinational state to control-word decoder
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Moore decode per state; only FETCH/MEMWR look at mem_ready and DECODE at opcode
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SHIFT;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !op_supported(opcode);
      end
      S_MEMADDR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main sequencing FSM for the multi-cycle MIPS core
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  ctrl_t      ctrl;
  ctrl_t      ctrl_g;

  // Next-state selection; MEMADDR steers on the opcode latched in DECODE
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADDR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // State and op registers; op is captured only while decoding
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  mc_output_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset silences every control line in the same cycle so an abandoned
  // instruction cannot issue a register or memory write
  assign ctrl_g = rst ? '0 : ctrl;

  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign IorD        = ctrl_g.iord;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign IRWrite     = ctrl_g.ir_write;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign RegDst      = ctrl_g.reg_dst;
  assign RegWrite    = ctrl_g.reg_write;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign ALUSrcB     = ctrl_g.alu_src_b;
  assign ALUop       = ctrl_g.alu_op;
  assign PCSource    = ctrl_g.pc_source;
  assign instr_done  = ctrl_g.instr_done;
  assign illegal_op  = ctrl_g.illegal_op;
  assign state       = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUop, PCSource;
  logic [3:0] state;

  int total = 0;
  int bad = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [21:0] obs_word();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, instr_done,
            illegal_op, state};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == JMP || op == ADDI;
  endfunction

  // Expected control word straight from the per-state output table
  function automatic logic [21:0] exp_word(input logic [3:0] s, input logic rdy, input logic ill);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, done;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, done} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      4'd0:        begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:        asb = 2'b11;
      4'd2, 4'd10: begin asa = 1; asb = 2'b10; end
      4'd3:        begin mr = 1; iord = 1; end
      4'd4:        begin rw = 1; m2r = 1; done = 1; end
      4'd5:        begin mw = 1; iord = 1; done = rdy; end
      4'd6:        begin asa = 1; aop = 2'b10; end
      4'd7:        begin rw = 1; rd = 1; done = 1; end
      4'd8:        begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      4'd9:        begin pcw = 1; pcs = 2'b10; done = 1; end
      4'd11:       begin rw = 1; done = 1; end
      default:     ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, done, ill, s};
  endfunction

  // Instruction length with no wait states, counted from FETCH to the final cycle
  function automatic int spec_cycles(input logic [5:0] op);
    case (op)
      LW:            return 5;
      SW, RT, ADDI:  return 4;
      BEQ, JMP:      return 3;
      default:       return 2;
    endcase
  endfunction

  task automatic step(input logic r, input logic rdy, input logic [5:0] op);
    @(negedge clk);
    rst = r; mem_ready = rdy; opcode = op;
    #1;
  endtask

  // Runs one instruction from FETCH: fw not-ready cycles in FETCH, aw in MEMRD/MEMWR
  task automatic run_instr(input logic [5:0] op, input int fw, input int aw, input string tag);
    logic [3:0]  ph[$];
    logic [3:0]  cur;
    logic        rdy, is_wait, ill, marker;
    logic [21:0] exp, obs;
    int          waited, cycles, done_at, nwait, want;
    case (op)
      LW:      ph = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      SW:      ph = '{4'd0, 4'd1, 4'd2, 4'd5};
      RT:      ph = '{4'd0, 4'd1, 4'd6, 4'd7};
      BEQ:     ph = '{4'd0, 4'd1, 4'd8};
      JMP:     ph = '{4'd0, 4'd1, 4'd9};
      ADDI:    ph = '{4'd0, 4'd1, 4'd10, 4'd11};
      default: ph = '{4'd0, 4'd1};
    endcase
    waited = 0; cycles = 0; done_at = -1;
    while (ph.size() > 0) begin
      cur = ph[0];
      is_wait = (cur == 4'd0) || (cur == 4'd3) || (cur == 4'd5);
      nwait = (cur == 4'd0) ? fw : aw;
      rdy = is_wait ? (waited >= nwait) : 1'($urandom_range(0, 1));
      step(1'b0, rdy, (cur == 4'd1) ? op : 6'($urandom_range(0, 63)));
      cycles++;
      ill = (cur == 4'd1) && !is_legal(op);
      exp = exp_word(cur, rdy, ill);
      obs = obs_word();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s op=%b cycle=%0d: got %h expected %h", tag, op, cycles, obs, exp);
      end
      marker = is_legal(op) ? instr_done : illegal_op;
      if (done_at < 0 && marker === 1'b1) done_at = cycles;
      if (is_wait && !rdy) waited++;
      else begin
        void'(ph.pop_front());
        waited = 0;
      end
    end
    want = spec_cycles(op) + fw + ((op == LW || op == SW) ? aw : 0);
    total++;
    if (done_at != want) begin
      bad++;
      $display("FAIL %s_latency op=%b: got %0d expected %0d", tag, op, done_at, want);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      total++;
      if (obs_word() !== 22'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d: got %h expected 0", i, obs_word());
      end
    end
  endtask

  task automatic test_directed;
    run_instr(LW, 0, 0, "lw");
    run_instr(SW, 0, 2, "sw_wait");
    run_instr(RT, 0, 0, "rtype");
    run_instr(BEQ, 0, 0, "beq");
    run_instr(JMP, 0, 0, "jump");
    run_instr(ADDI, 0, 0, "addi");
    run_instr(6'b111111, 0, 0, "illegal");
    run_instr(LW, 2, 3, "lw_wait");
  endtask

  task automatic test_reset_mid;
    step(1'b0, 1'b1, 6'($urandom_range(0, 63)));
    step(1'b0, 1'b1, LW);
    step(1'b0, 1'b1, 6'($urandom_range(0, 63)));
    step(1'b0, 1'b0, 6'($urandom_range(0, 63)));
    total++;
    if (state !== 4'd3) begin
      bad++;
      $display("FAIL mid_pre_state: got %0d expected 3", state);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      total++;
      if (obs_word() !== 22'd0) begin
        bad++;
        $display("FAIL mid_reset_outputs cycle=%0d: got %h expected 0", i, obs_word());
      end
    end
    run_instr(LW, 3, 1, "after_reset");
  endtask

  task automatic test_random;
    logic [5:0] ops[10] = '{LW, SW, RT, BEQ, JMP, ADDI, 6'b111111, 6'b000001, 6'b100100, 6'b110000};
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 9)], int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multi-cycle variant of the MIPS core. It sequences one instruction over 3–5 cycles through a shared ALU, a unified instruction/data memory and the register file. It issues the 2-bit `ALUop` that the existing ALU control decoder turns into the 4-bit ALU operation. The outputs are Moore-decoded from a registered state, except for the memory-ready qualifications listed below.

## Interface
- No parameters. Encodings are fixed in the shared package.
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: `IR[31:26]`; sampled only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load if ALU zero.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: register-file write data select; 1 = MDR.
- `RegDst` out 1: register-file write address select; 1 = rd, 0 = rt.
- `RegWrite` out 1: register-file write enable.
- `ALUSrcA` out 1: ALU A select; 0 = PC, 1 = A.
- `ALUSrcB` out 2: ALU B select; 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `ALUop` out 2: 00 = add, 01 = sub, 10 = decode by funct.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse in the final cycle of an instruction.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- **Supported opcodes:** R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- **States (4-bit encoding):** FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 are unreachable; they must decode to all-zero outputs and go to FETCH.
- **Transitions:**
  - FETCH → DECODE when `mem_ready`=1; otherwise stay in FETCH.
  - DECODE goes by opcode: lw/sw → MEMADDR, R-type → EXEC, beq → BRANCH, j → JUMP, addi → ADDIEX. Any other opcode → FETCH with `illegal_op`=1.
  - MEMADDR → MEMRD for lw, MEMWR for sw. The opcode used here is the one latched into the internal op register in DECODE.
  - MEMRD → MEMWB when `mem_ready`; otherwise stay.
  - MEMWR → FETCH when `mem_ready`; otherwise stay.
  - EXEC → ALUWB; ADDIEX → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.
- **Outputs:** any signal not listed for a state is 0.
  - FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUop`=00, `PCSource`=00. `IRWrite`=`PCWrite`=`mem_ready`.
  - DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUop`=00 (branch target precompute).
  - MEMADDR and ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00.
  - MEMRD: `MemRead`=1, `IorD`=1.
  - MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
  - MEMWR: `MemWrite`=1, `IorD`=1.
  - EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=10.
  - ALUWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0.
  - ADDIWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0.
  - BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=01, `PCWriteCond`=1, `PCSource`=01.
  - JUMP: `PCWrite`=1, `PCSource`=10.
- **`instr_done`:** 1 in MEMWB, ALUWB, ADDIWB, BRANCH and JUMP, and in MEMWR when `mem_ready`=1.

## Timing
- **Latency, `mem_ready` held at 1, FETCH to final state inclusive:** lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- **Wait states:** each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. `MemRead`/`MemWrite` and `IorD` stay stable throughout the wait.
- **Reset:** while `rst`=1 every output is forced to 0 (`state` reads 0). On the first edge after `rst` falls the block is in FETCH. A reset asserted mid-instruction abandons it; no `RegWrite`/`MemWrite` is issued in the reset cycle.
- **Illegal opcode:** `illegal_op` is high only in the DECODE cycle. The next cycle is FETCH, and PC has already advanced by 4.
- **`opcode` sampling:** `opcode` is ignored outside DECODE.

## Structure
- The shared package holds the opcode constants, the state enum/localparams, and the `ALUop` / `ALUSrcB` / `PCSource` encodings.
- One natural sub-module, `mc_output_decode`: a purely combinational state → control-word decoder. The top holds only the state and op registers and the next-state logic.

## Test plan
- lw, `mem_ready`=1: `state` sequence 0,1,2,3,4,0. `MemtoReg`=`RegWrite`=1 in cycle 5. `instr_done` high only in cycle 5.
- sw with `mem_ready`=0 for 2 cycles in MEMWR: `MemWrite`=1 and `IorD`=1 for 3 cycles. `instr_done` on the 3rd cycle only, then FETCH.
- R-type (000000): `ALUop`=10 and `ALUSrcA`=1 in EXEC. `RegDst`=`RegWrite`=1 next cycle. Total 4 cycles.
- beq: `ALUop`=01, `PCWriteCond`=1, `PCSource`=01 in cycle 3. j: `PCWrite`=1, `PCSource`=10 in cycle 3.
- opcode 111111: `illegal_op`=1 for exactly one cycle in DECODE. Next state 0. No `RegWrite`/`MemWrite` ever asserted.
- `rst` pulsed in MEMRD, and FETCH held with `mem_ready`=0 for 3 cycles: all outputs 0 during reset. FETCH follows the reset. `IRWrite`/`PCWrite` stay 0 until `mem_ready`=1.
